// File: rtl/wts_pkg.sv
// Shared constants and requester tag encodings for the wave-table RAM arbiter.
package wts_pkg;
    localparam int CH_NUM_DEF    = 5;
    localparam int WAVE_BITS_DEF = 5;
    localparam int CH_BITS_DEF   = 3;

    localparam logic [7:0] OOR_RD_VAL = 8'hFF;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_CH   = 2'd2
    } tag_t;
endpackage

// File: rtl/wts_rr_picker.sv
// Rotate-priority picker: first set request at or after ptr, wrapping at CH_NUM.
module wts_rr_picker
    import wts_pkg::*;
#(
    parameter int CH_NUM  = CH_NUM_DEF,
    parameter int CH_BITS = CH_BITS_DEF
) (
    input  logic [CH_NUM-1:0]  req,
    input  logic [CH_BITS-1:0] ptr,
    output logic [CH_NUM-1:0]  gnt,
    output logic               valid
);
    int idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < CH_NUM; i++) begin
            idx = int'(ptr) + i;
            if (idx >= CH_NUM) idx = idx - CH_NUM;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wts_wave_ram_arbiter.sv
// Single-port wave-table RAM arbiter: fixed-priority CPU port, round-robin channel fetchers,
// one grant per clock with a two-stage tag pipeline carrying each access to its ack.
module wts_wave_ram_arbiter
    import wts_pkg::*;
#(
    parameter int CH_NUM    = CH_NUM_DEF,
    parameter int WAVE_BITS = WAVE_BITS_DEF,
    parameter int CH_BITS   = CH_BITS_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpu_req,
    input  logic                          cpu_wr,
    input  logic [CH_BITS+WAVE_BITS-1:0]  cpu_a,
    input  logic [7:0]                    cpu_d,
    output logic [7:0]                    cpu_q,
    output logic                          cpu_ack,
    input  logic [CH_NUM-1:0]             ch_req,
    input  logic [CH_NUM*WAVE_BITS-1:0]   ch_idx,
    output logic [CH_NUM-1:0]             ch_ack,
    output logic [7:0]                    ch_q,
    output logic [CH_BITS+WAVE_BITS-1:0]  ram_a,
    output logic                          ram_we,
    output logic [7:0]                    ram_d,
    input  logic [7:0]                    ram_q
);
    localparam int AW = CH_BITS + WAVE_BITS;

    logic               cpu_pend;
    logic               pend_wr;
    logic [AW-1:0]      pend_a;
    logic [7:0]         pend_d;
    logic               pend_oor;
    logic               cpu_busy;

    tag_t               tag_p1, tag_p2;
    logic [CH_BITS-1:0] ch_p1, ch_p2;
    logic               wr_p1, wr_p2;
    logic               oor_p1, oor_p2;
    logic [CH_BITS-1:0] rr_ptr;

    logic [CH_NUM-1:0]    busy, elig, pick, ack_vec;
    logic                 pick_vld;
    logic [CH_BITS-1:0]   pick_ch, next_ptr;
    logic [WAVE_BITS-1:0] pick_idx;

    // A channel stays masked while its access occupies either tag stage.
    always_comb begin
        busy    = '0;
        ack_vec = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            busy[i]    = ((tag_p1 == TAG_CH) && (ch_p1 == CH_BITS'(i))) ||
                         ((tag_p2 == TAG_CH) && (ch_p2 == CH_BITS'(i)));
            ack_vec[i] = (tag_p2 == TAG_CH) && (ch_p2 == CH_BITS'(i));
        end
    end

    assign elig = ch_req & ~busy;

    wts_rr_picker #(
        .CH_NUM  (CH_NUM),
        .CH_BITS (CH_BITS)
    ) u_picker (
        .req   (elig),
        .ptr   (rr_ptr),
        .gnt   (pick),
        .valid (pick_vld)
    );

    always_comb begin
        pick_ch = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (pick[i]) pick_ch = CH_BITS'(i);
        end
    end

    assign next_ptr = (pick_ch == CH_BITS'(CH_NUM - 1)) ? '0 : pick_ch + 1'b1;
    assign pick_idx = ch_idx[int'(pick_ch)*WAVE_BITS +: WAVE_BITS];
    assign pend_oor = int'(pend_a[AW-1 -: CH_BITS]) >= CH_NUM;
    assign cpu_busy = (tag_p1 == TAG_CPU) || (tag_p2 == TAG_CPU);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_pend <= 1'b0;
            pend_wr  <= 1'b0;
            pend_a   <= '0;
            pend_d   <= '0;
            tag_p1   <= TAG_NONE;
            tag_p2   <= TAG_NONE;
            ch_p1    <= '0;
            ch_p2    <= '0;
            wr_p1    <= 1'b0;
            wr_p2    <= 1'b0;
            oor_p1   <= 1'b0;
            oor_p2   <= 1'b0;
            rr_ptr   <= '0;
            ram_a    <= '0;
            ram_we   <= 1'b0;
            ram_d    <= '0;
            cpu_q    <= '0;
            cpu_ack  <= 1'b0;
            ch_q     <= '0;
            ch_ack   <= '0;
        end else begin
            // A pending CPU request is always granted on the following edge.
            if (cpu_pend) begin
                cpu_pend <= 1'b0;
            end else if (cpu_req && !cpu_busy) begin
                cpu_pend <= 1'b1;
                pend_wr  <= cpu_wr;
                pend_a   <= cpu_a;
                pend_d   <= cpu_d;
            end

            // E0: grant and RAM issue
            ram_we <= 1'b0;
            tag_p1 <= TAG_NONE;
            wr_p1  <= 1'b0;
            oor_p1 <= 1'b0;
            if (cpu_pend) begin
                tag_p1 <= TAG_CPU;
                wr_p1  <= pend_wr;
                oor_p1 <= pend_oor;
                if (!pend_oor) begin
                    ram_a  <= pend_a;
                    ram_we <= pend_wr;
                    ram_d  <= pend_d;
                end
            end else if (pick_vld) begin
                tag_p1 <= TAG_CH;
                ch_p1  <= pick_ch;
                ram_a  <= {pick_ch, pick_idx};
                rr_ptr <= next_ptr;
            end

            // E1: RAM read in progress
            tag_p2 <= tag_p1;
            ch_p2  <= ch_p1;
            wr_p2  <= wr_p1;
            oor_p2 <= oor_p1;

            // E2: completion
            cpu_ack <= (tag_p2 == TAG_CPU);
            ch_ack  <= ack_vec;
            if ((tag_p2 == TAG_CPU) && !wr_p2) begin
                cpu_q <= oor_p2 ? OOR_RD_VAL : ram_q;
            end
            if (tag_p2 == TAG_CH) begin
                ch_q <= ram_q;
            end
        end
    end
endmodule

// File: doc/wts_wave_ram_arbiter.md
Name: wts_wave_ram_arbiter

Overview:
- Shares one single-port wave-table RAM (32 samples x 8 bit per channel) between the slot-side CPU port and the per-channel sample fetchers of the tone generator.
- Sits inside wts_core, between the rd/wr edge-detected slot requests and the channel oscillators.
- Pipelined: one RAM grant per clock. CPU has fixed priority; channels are served round-robin.

Parameters:
- CH_NUM, 5: number of tone channels sharing the RAM.
- WAVE_BITS, 5: sample index width (32 samples per channel).
- CH_BITS, 3: channel field width. Must satisfy 2**CH_BITS >= CH_NUM.

Ports:
- clk  in  1  system clock, 21.47727MHz.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  one-cycle request pulse from slot edge detect.
- cpu_wr  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_a  in  CH_BITS+WAVE_BITS  address: {channel, sample index}; sampled with cpu_req.
- cpu_d  in  8  write data; sampled with cpu_req.
- cpu_q  out  8  read data, valid while cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- ch_req  in  CH_NUM  level request per channel, held until its ch_ack.
- ch_idx  in  CH_NUM*WAVE_BITS  sample index per channel; stable while ch_req = 1.
- ch_ack  out  CH_NUM  one-hot, one-cycle completion pulse.
- ch_q  out  8  sample data, shared by all channels, valid with ch_ack.
- ram_a  out  CH_BITS+WAVE_BITS  registered RAM address.
- ram_we  out  1  registered write enable.
- ram_d  out  8  registered write data.
- ram_q  in  8  RAM read data; valid one clock after ram_a.

Behaviour:
- Reset values: cpu_q = 8'h00, cpu_ack = 0, ch_q = 8'h00, ch_ack = 0, ram_a = 0, ram_we = 0, ram_d = 0. Round-robin pointer = channel 0. All pending and in-flight flags cleared.
- CPU capture:
  - cpu_req sets cpu_pend and latches cpu_wr/cpu_a/cpu_d.
  - cpu_req while cpu_pend = 1 or a CPU access is in flight is ignored; the latched request is not overwritten.
- Grant (edge E0), one per clock. Priority order:
  - cpu_pend first.
  - Otherwise the first channel with ch_req = 1 and no access in flight, searching from (last granted channel + 1) mod CH_NUM with wrap-around.
  - A cpu_req arriving in the same cycle is first visible for grant on the next edge (pend register).
- Issue: at E0 the arbiter registers ram_a, ram_we, ram_d.
  - Channel access: ram_a = {ch, ch_idx[ch]}, ram_we = 0.
  - CPU access: ram_we = cpu_wr.
  - The round-robin pointer updates only on channel grants.
- Out-of-range CPU address (channel field >= CH_NUM): no RAM access, ram_we stays 0. The access is still acked at normal latency with cpu_q = 8'hFF.
- Completion: at E2 (two edges after grant) the arbiter registers ram_q into cpu_q or ch_q and pulses the matching ack for one cycle.
  - CPU writes ack at the same latency; cpu_q holds its previous value on a write ack.
- In-flight tracking: a per-requester 2-stage tag pipeline. A channel is not re-granted until its ack cycle, and may be granted again the cycle after its ack.
- Throughput: back-to-back grants to different requesters every clock. With all CH_NUM channels requesting continuously and no CPU traffic, each channel is served once per CH_NUM clocks.
- Simultaneous cpu_ack and ch_ack cannot occur (at most one grant per edge).
- Reset mid-operation: in-flight accesses are discarded and no ack is produced. ram_we drops asynchronously.

Decomposition:
- Shared include wts_pkg: CH_NUM, WAVE_BITS, CH_BITS defaults, the out-of-range read value 8'hFF, and the tag encodings (TAG_NONE, TAG_CPU, TAG_CH).
- Sub-module wts_rr_picker: combinational rotate-priority one-hot picker (request vector, pointer -> grant one-hot, valid).

Test Plan:
- Reset check: assert reset mid-access with ch_req[2] = 1 -> no ch_ack. After release, all outputs are zero and the first grant goes to channel 0 if ch_req = 5'b11111.
- CPU write then read: write 8'h5A at cpu_a = {3'd1, 5'd7}; ram_we pulses with ram_a = 8'h27 one cycle after grant; cpu_ack 2 edges after grant. A later read of the same address returns cpu_q = 8'h5A.
- Round-robin fairness: ch_req = 5'b11111 held for 20 clocks -> ch_ack order 0,1,2,3,4,0,... with each channel acked exactly 4 times.
- CPU priority: cpu_req pulses while all channels request -> the CPU is granted on the next edge and the channel sequence resumes at the pointer unchanged.
- Out-of-range access: CPU read at {3'd6, 5'd0} -> ram_we = 0, no RAM address change required, cpu_ack at normal latency with cpu_q = 8'hFF. A write to {3'd7, 5'd0} leaves RAM unmodified.
- Overrun: a second cpu_req one cycle after the first -> exactly one cpu_ack, and the data returned is for the first address.
